// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder: FSM state encoding,
// default bus widths and the default word type.
package mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/mem_responder_if.sv
// Memory handshake between the CPU control FSM (master) and the memory
// responder (slave): enable/direction/address/data in, read data and status out.
interface mem_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_ena;
  logic              wr_ena;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rdy;
  logic              busy;

  modport master (
    output mem_ena, wr_ena, addr, wdata,
    input  rdata, rdy, busy
  );

  modport slave (
    input  mem_ena, wr_ena, addr, wdata,
    output rdata, rdy, busy
  );
endinterface

// File: rtl/mem_array.sv
// Word array with one registered read port and two write ports; the preload
// port wins over the access port when both target the same word.
module mem_array #(
  parameter int AW    = 8,
  parameter int DW    = 16,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rdata,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          init_we,
  input  logic [AW-1:0] init_addr,
  input  logic [DW-1:0] init_data
);

  logic [DW-1:0] mem_r [DEPTH];

  // Storage update; contents survive reset. Both ports may commit in one cycle.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem_r[init_addr] <= init_data;
    end
    if (wr_en && !(init_we && (init_addr == wr_addr))) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read register samples the pre-edge contents, so a same-edge write is not seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= {DW{1'b0}};
    end else if (rd_en) begin
      rdata <= mem_r[rd_addr];
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one read/write per enable window, waits
// WAIT_CYCLES, completes against the on-chip array and holds rdy until release.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_responder_if.slave    bus,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e            state_r, state_nx;
  logic [3:0]        cnt_r, cnt_nx;
  logic [AW-1:0]     lat_addr_r;
  logic [DATA_W-1:0] lat_wdata_r;
  logic              lat_wr_r;
  logic              rdy_r, busy_r;
  logic              latch_s, rd_en_s, wr_en_s;
  logic [AW-1:0]     acc_addr_s;
  logic [DATA_W-1:0] acc_wdata_s;
  logic              unused_s;

  assign unused_s = ^{bus.addr[ADDR_W-1:AW], init_addr[ADDR_W-1:AW]};

  // Next-state, counter and array strobes for the access handshake.
  always_comb begin
    state_nx    = state_r;
    cnt_nx      = cnt_r;
    latch_s     = 1'b0;
    rd_en_s     = 1'b0;
    wr_en_s     = 1'b0;
    acc_addr_s  = lat_addr_r;
    acc_wdata_s = lat_wdata_r;
    case (state_r)
      IDLE: begin
        if (bus.mem_ena) begin
          latch_s = 1'b1;
          cnt_nx  = WAIT_INIT;
          if (WAIT_INIT == 4'd0) begin
            // Zero wait states: complete on the accept edge using the live bus.
            state_nx    = DONE;
            acc_addr_s  = bus.addr[AW-1:0];
            acc_wdata_s = bus.wdata;
            rd_en_s     = ~bus.wr_ena;
            wr_en_s     = bus.wr_ena;
          end else begin
            state_nx = BUSY;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      BUSY: begin
        if (!bus.mem_ena) begin
          state_nx = IDLE;
          cnt_nx   = 4'd0;
        end else if (cnt_r == 4'd1) begin
          state_nx = DONE;
          cnt_nx   = 4'd0;
          rd_en_s  = ~lat_wr_r;
          wr_en_s  = lat_wr_r;
        end else begin
          cnt_nx = cnt_r - 4'd1;
        end
      end
      DONE: begin
        if (!bus.mem_ena) begin
          state_nx = IDLE;
        end else begin
          state_nx = DONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // State, counter, request latch and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      lat_addr_r  <= {AW{1'b0}};
      lat_wdata_r <= {DATA_W{1'b0}};
      lat_wr_r    <= 1'b0;
      rdy_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      if (latch_s) begin
        lat_addr_r  <= bus.addr[AW-1:0];
        lat_wdata_r <= bus.wdata;
        lat_wr_r    <= bus.wr_ena;
      end
      rdy_r  <= (state_nx == DONE);
      busy_r <= (state_nx == BUSY);
    end
  end

  assign bus.rdy  = rdy_r;
  assign bus.busy = busy_r;

  // Reset aborts an access on the same edge, so gate both array strobes.
  mem_array #(
    .AW    (AW),
    .DW    (DATA_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (rd_en_s & ~reset),
    .rd_addr   (acc_addr_s),
    .rdata     (bus.rdata),
    .wr_en     (wr_en_s & ~reset),
    .wr_addr   (acc_addr_s),
    .wr_data   (acc_wdata_s),
    .init_we   (init_we),
    .init_addr (init_addr[AW-1:0]),
    .init_data (init_data)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: three instances (0, 1 and 3 wait states)
// checked cycle by cycle against a transaction-level memory model.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int DEPTH_TB = 256;

  logic clk;
  logic [2:0] reset_v, mem_ena, wr_ena, init_we, rdy, busy;
  logic [2:0][15:0] addr, wdata, init_addr, init_data, rdata;

  word_t model [3][DEPTH_TB];
  word_t exp_rd [3];
  int errs;
  int checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    assign bus.mem_ena = mem_ena[g];
    assign bus.wr_ena  = wr_ena[g];
    assign bus.addr    = addr[g];
    assign bus.wdata   = wdata[g];
    assign rdata[g]    = bus.rdata;
    assign rdy[g]      = bus.rdy;
    assign busy[g]     = bus.busy;

    mem_responder #(
      .ADDR_W      (16),
      .DATA_W      (16),
      .DEPTH       (DEPTH_TB),
      .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk       (clk),
      .reset     (reset_v[g]),
      .bus       (bus),
      .init_we   (init_we[g]),
      .init_addr (init_addr[g]),
      .init_data (init_data[g])
    );
  end

  function automatic int wait_of(int k);
    case (k)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(int k, string tag);
    check_eq({tag, " rdy"},   32'(rdy[k]),   32'd0);
    check_eq({tag, " busy"},  32'(busy[k]),  32'd0);
    check_eq({tag, " rdata"}, 32'(rdata[k]), 32'(exp_rd[k]));
  endtask

  task automatic preload(int k, logic [15:0] a, logic [15:0] d);
    init_we[k] = 1'b1; init_addr[k] = a; init_data[k] = d;
    tick();
    init_we[k] = 1'b0;
    model[k][int'(a) % DEPTH_TB] = d;
  endtask

  // Full access: enable held through accept, wait states and one DONE cycle.
  // cmode: 0 no preload, 1 preload same word on completion edge, 2 preload another word.
  task automatic do_access(int k, bit wr, logic [15:0] a, logic [15:0] d,
                           int cmode, logic [15:0] cd);
    int w = wait_of(k);
    int ea = int'(a) % DEPTH_TB;
    logic [15:0] ca;
    ca = 16'($urandom);
    if (cmode == 1) ca = {ca[15:8], a[7:0]};
    else if ((int'(ca) % DEPTH_TB) == ea) ca = ca ^ 16'h0001;
    mem_ena[k] = 1'b1; wr_ena[k] = wr; addr[k] = a; wdata[k] = d;
    for (int n = 0; n <= w + 1; n++) begin
      if (cmode != 0 && n == w) begin
        init_we[k] = 1'b1; init_addr[k] = ca; init_data[k] = cd;
      end
      tick();
      init_we[k] = 1'b0;
      if (n == w) begin
        if (wr) model[k][ea] = d;
        else exp_rd[k] = model[k][ea];
        if (cmode != 0) model[k][int'(ca) % DEPTH_TB] = cd;
      end
      check_eq($sformatf("acc k%0d n%0d rdy", k, n),   32'(rdy[k]),   32'(n >= w));
      check_eq($sformatf("acc k%0d n%0d busy", k, n),  32'(busy[k]),  32'(n < w));
      check_eq($sformatf("acc k%0d n%0d rdata", k, n), 32'(rdata[k]), 32'(exp_rd[k]));
      wr_ena[k] = 1'($urandom); addr[k] = 16'($urandom); wdata[k] = 16'($urandom);
    end
    mem_ena[k] = 1'b0;
    tick();
    check_idle(k, $sformatf("release k%0d", k));
  endtask

  // Enable dropped after BUSY sample nab: no commit, no rdy.
  task automatic abort_access(int k, bit wr, logic [15:0] a, logic [15:0] d, int nab);
    mem_ena[k] = 1'b1; wr_ena[k] = wr; addr[k] = a; wdata[k] = d;
    for (int n = 0; n <= nab; n++) begin
      tick();
      check_eq($sformatf("abort k%0d busy", k), 32'(busy[k]), 32'd1);
      check_eq($sformatf("abort k%0d rdy", k),  32'(rdy[k]),  32'd0);
    end
    mem_ena[k] = 1'b0;
    tick();
    check_idle(k, "abort exit");
    tick();
    check_idle(k, "abort settle");
  endtask

  task automatic reset_mid(int k, logic [15:0] a, logic [15:0] d);
    mem_ena[k] = 1'b1; wr_ena[k] = 1'b1; addr[k] = a; wdata[k] = d;
    tick();
    check_eq("rst_mid busy", 32'(busy[k]), 32'd1);
    reset_v[k] = 1'b1;
    tick();
    exp_rd[k] = 16'h0000;
    check_idle(k, "rst_mid");
    reset_v[k] = 1'b0; mem_ena[k] = 1'b0;
    tick();
    check_idle(k, "rst_mid after");
  endtask

  initial begin
    int w;
    errs = 0; checks = 0;
    reset_v = 3'b111; mem_ena = 3'b000; wr_ena = 3'b000; init_we = 3'b000;
    addr = '0; wdata = '0; init_addr = '0; init_data = '0;
    for (int k = 0; k < 3; k++) exp_rd[k] = 16'h0000;
    tick();
    tick();
    for (int k = 0; k < 3; k++) check_idle(k, $sformatf("reset k%0d", k));
    reset_v = 3'b000;

    // Fill every word of every instance so no read ever sees an unwritten word.
    for (int i = 0; i < DEPTH_TB; i++) begin
      init_we = 3'b111;
      for (int k = 0; k < 3; k++) begin
        init_addr[k] = 16'(i); init_data[k] = 16'($urandom);
        model[k][i] = init_data[k];
      end
      tick();
    end
    init_we = 3'b000;

    preload(1, 16'h0010, 16'h1234);
    do_access(1, 1'b0, 16'h0010, 16'h0000, 0, 16'h0000);
    check_eq("tp read 0x10", 32'(rdata[1]), 32'h1234);

    do_access(1, 1'b1, 16'h0020, 16'hBEEF, 0, 16'h0000);
    do_access(1, 1'b0, 16'h0020, 16'h0000, 0, 16'h0000);
    check_eq("tp write 0x20", 32'(rdata[1]), 32'hBEEF);

    preload(1, 16'h0030, 16'h0000);
    abort_access(1, 1'b1, 16'h0030, 16'h5555, 0);
    do_access(1, 1'b0, 16'h0030, 16'h0000, 0, 16'h0000);
    check_eq("tp abort 0x30", 32'(rdata[1]), 32'h0000);

    for (int k = 0; k < 3; k++) begin
      preload(k, 16'h0005, 16'hA5A5);
      do_access(k, 1'b0, 16'h0105, 16'h0000, 0, 16'h0000);
      check_eq($sformatf("tp wrap k%0d", k), 32'(rdata[k]), 32'hA5A5);
    end

    preload(1, 16'h0040, 16'h7777);
    reset_mid(1, 16'h0040, 16'h9999);
    do_access(1, 1'b0, 16'h0040, 16'h0000, 0, 16'h0000);
    check_eq("tp reset 0x40", 32'(rdata[1]), 32'h7777);

    preload(1, 16'h0050, 16'h2222);
    do_access(1, 1'b0, 16'h0050, 16'h0000, 1, 16'h1111);
    check_eq("tp rbw old", 32'(rdata[1]), 32'h2222);
    do_access(1, 1'b0, 16'h0050, 16'h0000, 0, 16'h0000);
    check_eq("tp rbw new", 32'(rdata[1]), 32'h1111);

    // Random mix of reads, writes, aborts and colliding preloads per instance.
    for (int k = 0; k < 3; k++) begin
      w = wait_of(k);
      for (int i = 0; i < 60; i++) begin
        if (w > 0 && $urandom_range(0, 9) < 2)
          abort_access(k, 1'($urandom), 16'($urandom), 16'($urandom),
                       int'($urandom_range(0, w - 1)));
        else
          do_access(k, 1'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 5)) % 3 == 0 ? int'($urandom_range(1, 2)) : 0,
                    16'($urandom));
      end
      for (int i = 0; i < 16; i++)
        do_access(k, 1'b0, 16'($urandom), 16'h0000, 0, 16'h0000);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
